// File: rtl/uart_sender_if.sv
// rtl/uart_sender_if.sv - byte push handshake between peripheral logic and uart_sender
interface uart_sender_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_sender.sv
// rtl/uart_sender.sv - buffered 8N1 UART transmitter, LSB first, FIFO-fed serializer
module uart_sender #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          sysclk,
    input  logic                          reset,
    uart_sender_if.slave                  tx,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, fifo_empty;

    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic          baud_done;
    logic          load;

    // Ready comes only from the registered count, so a pop on the same edge
    // never lets a push into a full FIFO.
    assign tx.tx_ready = (count != DEPTH_C);
    assign fifo_empty  = (count == '0);
    assign push        = tx.tx_valid && tx.tx_ready;
    assign baud_done   = (baud_cnt == BAUD_LAST);
    assign tx_busy     = (state != S_IDLE) || !fifo_empty;
    assign fifo_count  = count;

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr] <= tx.tx_data;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!fifo_empty) state_next = S_START;
            S_START: if (baud_done) state_next = S_DATA;
            S_DATA:  if (baud_done && (bit_idx == 3'd7)) state_next = S_STOP;
            S_STOP:  if (baud_done) state_next = fifo_empty ? S_IDLE : S_START;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        case (state)
            S_IDLE:  load = !fifo_empty;
            S_STOP:  load = baud_done && !fifo_empty;
            default: load = 1'b0;
        endcase
        pop = load;
    end

    // txd is registered alongside the shifter so the pin only changes on clock edges.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            txd      <= 1'b1;
        end else if (load) begin
            shift    <= mem[rd_ptr];
            bit_idx  <= '0;
            baud_cnt <= '0;
            txd      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    txd      <= 1'b1;
                end
                S_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd <= 1'b1;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    txd <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    txd      <= 1'b1;
                end
            endcase
        end
    end
endmodule
